fc_output_accumulator: RTL

- Final fully-connected layer of the digit classifier. Streams one activation per handshake and multiply-accumulates it against 10 per-class weights.
- Produces ten signed 26-bit class scores Out_0..Out_9, which feed the downstream max-selector stage directly.
- One frame = N_INPUTS accepted activations. Scores are held stable with Out_valid until the consumer acknowledges them.

---
 rtl/fc_output_accumulator_if.sv | 28 ++
 rtl/fc_output_accumulator.sv | 115 +++++++++++
 2 files changed

// File: rtl/fc_output_accumulator_if.sv
// Handshake bundle for fc_output_accumulator: activation/weight input stream and
// the ten-score output stream.
interface fc_output_accumulator_if #(
    parameter int X_W   = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 26
);
    logic                    In_valid;
    logic                    In_ready;
    logic [X_W-1:0]          X_in;
    logic [10*W_W-1:0]       W_in;
    logic                    Out_valid;
    logic                    Out_ready;
    logic signed [ACC_W-1:0] Out_0, Out_1, Out_2, Out_3, Out_4;
    logic signed [ACC_W-1:0] Out_5, Out_6, Out_7, Out_8, Out_9;

    modport master (
        output In_valid, X_in, W_in, Out_ready,
        input  In_ready, Out_valid,
        input  Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7, Out_8, Out_9
    );

    modport slave (
        input  In_valid, X_in, W_in, Out_ready,
        output In_ready, Out_valid,
        output Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7, Out_8, Out_9
    );
endinterface

// File: rtl/fc_output_accumulator.sv
// Final FC layer: MACs N_INPUTS activations against 10 class weights per frame.
// Define FC_ACC_SATURATE_EN to clamp each accumulate step instead of wrapping.
module fc_output_accumulator #(
    parameter int N_INPUTS = 784,
    parameter int X_W      = 8,
    parameter int W_W      = 8,
    parameter int ACC_W    = 26,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic GlobalReset,
    fc_output_accumulator_if.slave bus
);
    localparam int P_W = X_W + W_W + 1;
    localparam int S_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    typedef enum logic {ACCUM, DONE} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] acc_q [10];
    logic signed [ACC_W-1:0] acc_d [10];
    logic signed [ACC_W-1:0] mac   [10];
    logic signed [P_W-1:0]   xs, ws, prod;
    logic signed [S_W-1:0]   sum;

    // Sum is formed one bit wider than the accumulator so overflow is visible.
    always_comb begin
        xs   = '0;
        ws   = '0;
        prod = '0;
        sum  = '0;
        for (int unsigned k = 0; k < 10; k++) begin
            xs   = P_W'($signed({1'b0, bus.X_in}));
            ws   = P_W'($signed(bus.W_in[W_W*k +: W_W]));
            prod = xs * ws;
            sum  = S_W'(acc_q[k]) + S_W'(prod);
`ifdef FC_ACC_SATURATE_EN
            if (sum[S_W-1] != sum[S_W-2])
                mac[k] = sum[S_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                mac[k] = sum[ACC_W-1:0];
`else
            mac[k] = sum[ACC_W-1:0];
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        case (state_q)
            ACCUM: begin
                if (bus.In_valid && in_ready_q) begin
                    acc_d = mac;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d       = '0;
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_valid_q && bus.Out_ready) begin
                    for (int unsigned k = 0; k < 10; k++) acc_d[k] = '0;
                    state_d     = ACCUM;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ACCUM;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int unsigned k = 0; k < 10; k++) acc_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.In_ready  = in_ready_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.Out_0 = acc_q[0];
    assign bus.Out_1 = acc_q[1];
    assign bus.Out_2 = acc_q[2];
    assign bus.Out_3 = acc_q[3];
    assign bus.Out_4 = acc_q[4];
    assign bus.Out_5 = acc_q[5];
    assign bus.Out_6 = acc_q[6];
    assign bus.Out_7 = acc_q[7];
    assign bus.Out_8 = acc_q[8];
    assign bus.Out_9 = acc_q[9];
endmodule
